ltssm_lane_ctrl: RTL and testbench

Parametrised per-link lane controller that sits between core_fsm and the NUM_LANES ts_gen/tsa lane pairs. It replaces fixed 4-lane bit-bundling with four functions:
- link-width resolution from receiver detect;
- lane-number checking with degrade and lane reversal;
- persistence-qualified all-lane TSA condition flags;
- a single ts_update/ack handshake fanned out to active lanes only, with timeout.

---
 rtl/ltssm_lane_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ltssm_lane_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ltssm_lane_ctrl.sv
// Per-link lane controller: width resolve, lane-number check/degrade/reversal (LTSSM_LANE_REVERSAL_EN), flag qualify, update fan-out.
// Latency: every output is registered, one cycle after the causing input.
// Backpressure: none; ts_update while waiting is dropped, outstanding update ends in ack, timeout or abort.
module ltssm_lane_ctrl #(
  parameter int NUM_LANES   = 4,
  parameter int PERSIST     = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_LANES-1:0]     rx_det,
  input  logic                     det_latch,
  input  logic                     cfg_done,
  input  logic [8*NUM_LANES-1:0]   lane_num,
  input  logic [NUM_LANES-1:0]     lane_num_vld,
  input  logic [NUM_LANES-1:0]     lane_flag,
  input  logic                     ts_update,
  input  logic [NUM_LANES-1:0]     lane_update_ack,
  output logic [NUM_LANES-1:0]     lane_ts_update,
  output logic                     ts_update_ack,
  output logic                     ts_update_timeout,
  output logic                     flag_all,
  output logic                     flag_any,
  output logic [NUM_LANES-1:0]     active_mask,
  output logic [4:0]               link_width,
  output logic                     lane_reversed
);

  localparam int CW = $clog2(PERSIST + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic {U_IDLE, U_WAIT} ustate_t;

  ustate_t              state;
  logic [NUM_LANES-1:0] pending;
  logic [TW-1:0]        timer;
  logic [CW-1:0]        cnt [NUM_LANES];

  logic [NUM_LANES-1:0] straight, qual, det_mask, cfg_mask, mask_nxt, pend_nxt;
  logic [4:0]           det_w, cfg_width;
  logic                 cfg_rev;

  function automatic logic [NUM_LANES-1:0] lmask(input int w);
    return NUM_LANES'((32'd1 << w) - 32'd1);
  endfunction

  always_comb begin
    det_w = '0;
    for (int k = 0; k < 5; k++)
      if ((1 << k) <= NUM_LANES && &(rx_det | ~lmask(1 << k)))
        det_w = 5'(1 << k);
    det_mask = lmask(int'(det_w));
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      straight[i] = lane_num_vld[i] && (lane_num[8*i +: 8] == 8'(i));
      qual[i]     = (cnt[i] == CW'(PERSIST));
    end
  end

`ifdef LTSSM_LANE_REVERSAL_EN
  logic [NUM_LANES-1:0] reversed;
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++)
      reversed[i] = lane_num_vld[i] && (lane_num[8*i +: 8] == 8'(int'(link_width) - 1 - i));
  end
`endif

  // active_mask is always a contiguous low-lane prefix, so "all active lanes" is a masked AND
  always_comb begin
    cfg_mask  = active_mask;
    cfg_width = link_width;
    cfg_rev   = lane_reversed;
    if (&(straight | ~active_mask)) begin
      cfg_rev = 1'b0;
    end
`ifdef LTSSM_LANE_REVERSAL_EN
    else if (link_width > 5'd1 && &(reversed | ~active_mask)) begin
      cfg_rev = 1'b1;
    end
`endif
    else begin
      cfg_rev   = 1'b0;
      cfg_mask  = '0;
      cfg_width = '0;
      for (int k = 0; k < 5; k++)
        if ((1 << k) <= NUM_LANES && 5'(1 << k) < link_width && &(straight | ~lmask(1 << k))) begin
          cfg_mask  = lmask(1 << k);
          cfg_width = 5'(1 << k);
        end
    end
  end

  always_comb begin
    mask_nxt = det_latch ? det_mask : (cfg_done ? cfg_mask : active_mask);
    pend_nxt = pending & ~lane_update_ack & mask_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= U_IDLE;
      pending           <= '0;
      timer             <= '0;
      lane_ts_update    <= '0;
      ts_update_ack     <= 1'b0;
      ts_update_timeout <= 1'b0;
      flag_all          <= 1'b0;
      flag_any          <= 1'b0;
      active_mask       <= '0;
      link_width        <= '0;
      lane_reversed     <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
    end else begin
      lane_ts_update    <= '0;
      ts_update_ack     <= 1'b0;
      ts_update_timeout <= 1'b0;

      if (det_latch) begin
        active_mask   <= det_mask;
        link_width    <= det_w;
        lane_reversed <= 1'b0;
      end else if (cfg_done) begin
        active_mask   <= cfg_mask;
        link_width    <= cfg_width;
        lane_reversed <= cfg_rev;
      end

      // lanes dropped this cycle by a detect or a degrade lose their history
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!det_latch && lane_flag[i] && active_mask[i] && mask_nxt[i])
          cnt[i] <= qual[i] ? cnt[i] : cnt[i] + CW'(1);
        else
          cnt[i] <= '0;
      end
      flag_all <= (active_mask != '0) && &(qual | ~active_mask);
      flag_any <= |(qual & active_mask);

      case (state)
        U_IDLE: begin
          if (ts_update) begin
            if (active_mask == '0) begin
              ts_update_ack <= 1'b1;
            end else begin
              lane_ts_update <= active_mask;
              pending        <= active_mask;
              timer          <= '0;
              state          <= U_WAIT;
            end
          end
        end
        U_WAIT: begin
          if (det_latch) begin
            pending <= '0;
            state   <= U_IDLE;
          end else if (pend_nxt == '0) begin
            pending       <= '0;
            ts_update_ack <= 1'b1;
            state         <= U_IDLE;
          end else if (timer == TW'(ACK_TIMEOUT)) begin
            // timer is 0 on the request cycle, so expiry lands ACK_TIMEOUT+1 cycles after it
            pending           <= '0;
            ts_update_timeout <= 1'b1;
            state             <= U_IDLE;
          end else begin
            pending <= pend_nxt;
            timer   <= timer + TW'(1);
          end
        end
        default: state <= U_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltssm_lane_ctrl.sv
// Bench for ltssm_lane_ctrl (4 lanes, PERSIST=8, ACK_TIMEOUT=16): vector table for width/config, directed update and flag sequences.
module tb_ltssm_lane_ctrl;

  localparam int N = 4;
`ifdef LTSSM_LANE_REVERSAL_EN
  localparam logic REV_EN = 1'b1;
`else
  localparam logic REV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] rx_det;
  logic         det_latch, cfg_done;
  logic [8*N-1:0] lane_num;
  logic [N-1:0] lane_num_vld, lane_flag, lane_update_ack;
  logic         ts_update;
  logic [N-1:0] lane_ts_update, active_mask;
  logic         ts_update_ack, ts_update_timeout, flag_all, flag_any, lane_reversed;
  logic [4:0]   link_width;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ltssm_lane_ctrl #(.NUM_LANES(N), .PERSIST(8), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .rx_det(rx_det), .det_latch(det_latch), .cfg_done(cfg_done),
    .lane_num(lane_num), .lane_num_vld(lane_num_vld), .lane_flag(lane_flag),
    .ts_update(ts_update), .lane_update_ack(lane_update_ack),
    .lane_ts_update(lane_ts_update), .ts_update_ack(ts_update_ack),
    .ts_update_timeout(ts_update_timeout), .flag_all(flag_all), .flag_any(flag_any),
    .active_mask(active_mask), .link_width(link_width), .lane_reversed(lane_reversed)
  );

  typedef struct {
    logic [3:0]  rx;
    logic        det;
    logic        cfg;
    logic [31:0] ln;
    logic [3:0]  vld;
    logic [3:0]  e_mask;
    logic [4:0]  e_width;
    logic        e_rev;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, ".upd"},   32'(lane_ts_update), 32'h0);
    check({nm, ".ack"},   32'(ts_update_ack), 32'h0);
    check({nm, ".tmo"},   32'(ts_update_timeout), 32'h0);
    check({nm, ".all"},   32'(flag_all), 32'h0);
    check({nm, ".any"},   32'(flag_any), 32'h0);
    check({nm, ".mask"},  32'(active_mask), 32'h0);
    check({nm, ".width"}, 32'(link_width), 32'h0);
    check({nm, ".rev"},   32'(lane_reversed), 32'h0);
  endtask

  task automatic do_det(input logic [3:0] rx);
    rx_det = rx;
    det_latch = 1'b1;
    @(negedge clk);
    det_latch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'hF, 1, 0, 32'h0,        4'h0, 4'hF, 5'd4, 1'b0};
    vecs[1]  = '{4'h7, 1, 0, 32'h0,        4'h0, 4'h3, 5'd2, 1'b0};
    vecs[2]  = '{4'hE, 1, 0, 32'h0,        4'h0, 4'h0, 5'd0, 1'b0};
    vecs[3]  = '{4'hF, 1, 0, 32'h0,        4'h0, 4'hF, 5'd4, 1'b0};
    vecs[4]  = '{4'h0, 0, 1, 32'h03020100, 4'hF, 4'hF, 5'd4, 1'b0};
    vecs[5]  = '{4'h0, 0, 1, 32'h00010203, 4'hF, REV_EN ? 4'hF : 4'h0, REV_EN ? 5'd4 : 5'd0, REV_EN};
    vecs[6]  = '{4'hF, 1, 0, 32'h0,        4'h0, 4'hF, 5'd4, 1'b0};
    vecs[7]  = '{4'h0, 0, 1, 32'h02030100, 4'hF, 4'h3, 5'd2, 1'b0};
    vecs[8]  = '{4'h0, 0, 1, 32'h02030100, 4'hF, 4'h3, 5'd2, 1'b0};
    vecs[9]  = '{4'hF, 1, 1, 32'h07070707, 4'hF, 4'hF, 5'd4, 1'b0};
    vecs[10] = '{4'h0, 0, 1, 32'h03020100, 4'hE, 4'h0, 5'd0, 1'b0};
    vecs[11] = '{4'h3, 1, 0, 32'h0,        4'h0, 4'h3, 5'd2, 1'b0};
    vecs[12] = '{4'h0, 0, 1, 32'h00000001, 4'h3, REV_EN ? 4'h3 : 4'h0, REV_EN ? 5'd2 : 5'd0, REV_EN};
    vecs[13] = '{4'h1, 1, 0, 32'h0,        4'h0, 4'h1, 5'd1, 1'b0};
    vecs[14] = '{4'h0, 1, 0, 32'h0,        4'h0, 4'h0, 5'd0, 1'b0};
    vecs[15] = '{4'h0, 0, 1, 32'h0,        4'h0, 4'h0, 5'd0, 1'b0};

    rst = 1'b1; rx_det = '0; det_latch = 0; cfg_done = 0; lane_num = '0;
    lane_num_vld = '0; lane_flag = '0; ts_update = 0; lane_update_ack = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rx_det = vecs[i].rx; det_latch = vecs[i].det; cfg_done = vecs[i].cfg;
      lane_num = vecs[i].ln; lane_num_vld = vecs[i].vld;
      @(negedge clk);
      det_latch = 0; cfg_done = 0;
      check($sformatf("vec%0d.mask", i),  32'(active_mask), 32'(vecs[i].e_mask));
      check($sformatf("vec%0d.width", i), 32'(link_width), 32'(vecs[i].e_width));
      check($sformatf("vec%0d.rev", i),   32'(lane_reversed), 32'(vecs[i].e_rev));
    end

    // handshake: acks spread over several cycles, stray ts_update and duplicate ack ignored
    do_det(4'hF);
    for (int c = 0; c <= 12; c++) begin
      check($sformatf("hs.upd c%0d", c), 32'(lane_ts_update), (c == 1) ? 32'hF : 32'h0);
      check($sformatf("hs.ack c%0d", c), 32'(ts_update_ack), 32'(c == 10));
      check($sformatf("hs.tmo c%0d", c), 32'(ts_update_timeout), 32'h0);
      ts_update = (c == 0) || (c == 4);
      lane_update_ack = (c == 3) ? 4'h1 : (c == 5) ? 4'h6 : (c == 7) ? 4'h1 : (c == 9) ? 4'h8 : 4'h0;
      @(negedge clk);
    end
    ts_update = 0; lane_update_ack = '0;

    // lane 2 never acks in time; late ack is ignored
    for (int c = 0; c <= 22; c++) begin
      check($sformatf("to.upd c%0d", c), 32'(lane_ts_update), (c == 1) ? 32'hF : 32'h0);
      check($sformatf("to.tmo c%0d", c), 32'(ts_update_timeout), 32'(c == 18));
      check($sformatf("to.ack c%0d", c), 32'(ts_update_ack), 32'h0);
      ts_update = (c == 0);
      lane_update_ack = (c == 2) ? 4'hB : (c == 20) ? 4'h4 : 4'h0;
      @(negedge clk);
    end

    // final ack on the expiry cycle wins
    for (int c = 0; c <= 20; c++) begin
      check($sformatf("race.ack c%0d", c), 32'(ts_update_ack), 32'(c == 18));
      check($sformatf("race.tmo c%0d", c), 32'(ts_update_timeout), 32'h0);
      ts_update = (c == 0);
      lane_update_ack = (c == 2) ? 4'h7 : (c == 17) ? 4'h8 : 4'h0;
      @(negedge clk);
    end

    // degrade while waiting removes the remaining pending lanes
    for (int c = 0; c <= 6; c++) begin
      check($sformatf("cfgw.ack c%0d", c), 32'(ts_update_ack), 32'(c == 4));
      ts_update = (c == 0);
      lane_update_ack = (c == 2) ? 4'h3 : 4'h0;
      cfg_done = (c == 3); lane_num = 32'h02030100; lane_num_vld = 4'hF;
      @(negedge clk);
    end
    check("cfgw.mask", 32'(active_mask), 32'h3);

    // detect aborts an outstanding update silently
    do_det(4'hF);
    for (int c = 0; c <= 22; c++) begin
      check($sformatf("abort.ack c%0d", c), 32'(ts_update_ack), 32'h0);
      check($sformatf("abort.tmo c%0d", c), 32'(ts_update_timeout), 32'h0);
      ts_update = (c == 0);
      det_latch = (c == 3);
      @(negedge clk);
    end
    det_latch = 0;

    // persistence: lane 3 drops for one cycle
    for (int c = 0; c <= 16; c++) begin
      check($sformatf("flag.all c%0d", c), 32'(flag_all), 32'(c >= 15));
      check($sformatf("flag.any c%0d", c), 32'(flag_any), 32'(c >= 9));
      lane_flag = (c == 5) ? 4'h7 : 4'hF;
      @(negedge clk);
    end
    lane_flag = '0;
    repeat (2) @(negedge clk);
    check("flag.drop.all", 32'(flag_all), 32'h0);
    check("flag.drop.any", 32'(flag_any), 32'h0);

    // inactive lanes do not block flag_all
    lane_flag = 4'h3;
    do_det(4'h3);
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("flag2.all c%0d", c), 32'(flag_all), 32'(c >= 10));
      @(negedge clk);
    end
    lane_flag = '0;

    // reset while waiting, then an empty-link update
    do_det(4'hF);
    ts_update = 1; @(negedge clk);
    ts_update = 0; repeat (2) @(negedge clk);
    rst = 1; @(negedge clk);
    rst = 0;
    check_zero("rst_mid");
    lane_update_ack = 4'hF; @(negedge clk);
    check("rst.late_ack", 32'(ts_update_ack), 32'h0);
    lane_update_ack = '0; ts_update = 1; @(negedge clk);
    ts_update = 0;
    check("rst.empty.ack", 32'(ts_update_ack), 32'h1);
    check("rst.empty.upd", 32'(lane_ts_update), 32'h0);
    @(negedge clk);
    check("rst.empty.ack2", 32'(ts_update_ack), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
